systolic_cycle_scheduler: RTL and testbench
===========================================

Name: systolic_cycle_scheduler

Overview:
- Sequences one output-stationary ROWS x COLS MAC array tile: clears accumulators, streams K operand words from the A/B buffers, gates edge feeds and fires the per-PE result-latch (control) pulse on the correct anti-diagonal cycle.
- Sits between the host/tile loop and the PE array plus its external skew delay chains; one tile in flight at a time.

Parameters:
ROWS, 4, array rows
COLS, 4, array columns
K_MAX, 256, max reduction length
AW, 8, buffer address width
RD_LAT, 1, buffer read latency in cycles (1..3)
KW, $clog2(K_MAX+1), k_len width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  tile request, sampled in IDLE only
k_len  in  KW  reduction length, sampled with start
a_base  in  AW  A buffer base address, sampled with start
b_base  in  AW  B buffer base address, sampled with start
busy  out  1  high from cycle after start accept until done cycle inclusive
done  out  1  one-cycle pulse; out_c of all PEs valid
arr_clr  out  1  one-cycle pulse; top ORs into array reset
a_rd_en  out  1  A buffer read strobe
a_rd_addr  out  AW  A read address
b_rd_en  out  1  B buffer read strobe
b_rd_addr  out  AW  B read address
row_feed_en  out  ROWS  row i edge mux passes data when 1, else zero
col_feed_en  out  COLS  column j edge mux passes data when 1, else zero
latch  out  ROWS*COLS  PE control; bit i*COLS+j drives PE(i,j)

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0; applies mid-tile (abort, no done).
- FSM: IDLE -> CLR -> FEED -> DRAIN -> DONE -> IDLE.
- Cycle 0: IDLE with start=1 accepts; latches k_len (saturate to K_MAX if larger), a_base, b_base.
- Cycle 1 CLR: arr_clr=1.
- Cycles 2..k_len+1 FEED: a_rd_en=b_rd_en=1, addresses base+k, k=0..k_len-1; addresses wrap modulo 2^AW.
- F0 = 2+RD_LAT. row_feed_en[i] high cycles F0+i .. F0+i+k_len-1; col_feed_en[j] likewise with j.
- latch[i*COLS+j] high exactly one cycle: F0+k_len+i+j. PE latches accumulator at end of that cycle.
- DRAIN until last latch (F0+k_len+ROWS+COLS-2); done pulses the next cycle (DONE state); return to IDLE.
- Default 4x4, k_len=8: reads cycles 2..9, latch[0] cycle 11, latch[15] cycle 17, done cycle 18.
- k_len=0: CLR then DONE directly (cycle 2); no reads, feeds or latches.
- start while busy: ignored, no queueing. start in DONE cycle ignored; accepted from next IDLE cycle.
- Results held in PE out_c until next tile's arr_clr; consumer must read before next start.
- Feed/latch windows from one phase counter (width covers F0+K_MAX+ROWS+COLS).

Optional Feature:
- Macro SCHED_PERF_CNT_EN.
- Defined: adds outputs perf_busy_cyc[31:0] (counts busy cycles) and perf_tiles[15:0] (increments on done); both wrap, cleared only by rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package systolic_sched_pkg: FSM state enum, F0 offset constant, DIAGS = ROWS+COLS-1, latch index function i*COLS+j.
- Sub-module sched_diag_shift: DIAGS-bit shift register seeded with one pulse at F0+k_len; latch[i][j] = diag[i+j]; also generates row/col enables from a k_len-wide pulse shifted per index.

Test Plan:
- rst, start, k_len=8, bases 0x10/0x20, 4x4 -> arr_clr cycle 1; reads addr 0x10..0x17/0x20..0x27 cycles 2..9; latch[0] cycle 11, latch[15] cycle 17; done cycle 18; busy cycles 1..18.
- Identity A, B=ramp, k_len=4, array model -> every PE out_c equals reference product at done; no accumulation outside feed windows.
- a_base=0xFE, k_len=4 -> addresses 0xFE,0xFF,0x00,0x01.
- k_len=0 -> arr_clr cycle 1, done cycle 2, zero read strobes and latches.
- start re-asserted during FEED, then rst=1 at cycle 6 -> start ignored; all outputs 0 cycle 7, no done; new start accepted cycle 8.
- Two back-to-back tiles, k_len=K_MAX+5 on second -> second saturates to 256 reads; perf_tiles=2 when SCHED_PERF_CNT_EN defined.

Source files
------------

// File: rtl/systolic_cycle_scheduler_pkg.sv
// Shared types and constants for the systolic tile scheduler.
// Phase numbering counts cycles from the start-accept cycle (cycle 0).
package systolic_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_FEED,
      S_DRAIN,
      S_DONE
   } sched_state_t;

   localparam int unsigned FEED_PHASE0 = 2;

   // First edge-feed cycle: the first read is issued in cycle 2, and the
   // data appears RD_LAT cycles later.
   function automatic int unsigned f0_off(input int unsigned rd_lat);
      return FEED_PHASE0 + rd_lat;
   endfunction

   function automatic int unsigned diags(input int unsigned rows, input int unsigned cols);
      return rows + cols - 1;
   endfunction

   function automatic int unsigned latch_idx(input int unsigned i, input int unsigned j,
                                             input int unsigned cols);
      return i * cols + j;
   endfunction

   function automatic int unsigned phase_w(input int unsigned rd_lat, input int unsigned k_max,
                                           input int unsigned rows, input int unsigned cols);
      return $clog2(f0_off(rd_lat) + k_max + rows + cols + 1);
   endfunction

endpackage

// File: rtl/systolic_cycle_scheduler_if.sv
// Host/array-facing bundle of the scheduler: tile request and buffer/array controls.
// The master modport is the scheduler's view; the slave modport is the host/array view.
interface systolic_cycle_scheduler_if #(
   parameter int unsigned ROWS  = 4,
   parameter int unsigned COLS  = 4,
   parameter int unsigned K_MAX = 256,
   parameter int unsigned AW    = 8,
   parameter int unsigned KW    = $clog2(K_MAX + 1)
);
   logic                   start;
   logic [KW-1:0]          k_len;
   logic [AW-1:0]          a_base;
   logic [AW-1:0]          b_base;
   logic                   busy;
   logic                   done;
   logic                   arr_clr;
   logic                   a_rd_en;
   logic [AW-1:0]          a_rd_addr;
   logic                   b_rd_en;
   logic [AW-1:0]          b_rd_addr;
   logic [ROWS-1:0]        row_feed_en;
   logic [COLS-1:0]        col_feed_en;
   logic [ROWS*COLS-1:0]   latch;

   modport master (
      input  start, k_len, a_base, b_base,
      output busy, done, arr_clr, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
             row_feed_en, col_feed_en, latch
   );

   modport slave (
      output start, k_len, a_base, b_base,
      input  busy, done, arr_clr, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
             row_feed_en, col_feed_en, latch
   );
endinterface

// File: rtl/systolic_cycle_scheduler_diag.sv
// Edge-feed and anti-diagonal latch pulse generator for the tile scheduler.
// One seed pulse walks the diagonals; one k_len-wide feed window walks the row/column indices.
module sched_diag_shift
   import systolic_sched_pkg::*;
#(
   parameter int unsigned ROWS = 4,
   parameter int unsigned COLS = 4,
   parameter int unsigned KW   = 9,
   parameter int unsigned PW   = 9,
   parameter int unsigned F0   = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_active,
   input  logic [PW-1:0]        i_phase,
   input  logic [KW-1:0]        i_k_len,
   output logic [ROWS-1:0]      o_row_feed_en,
   output logic [COLS-1:0]      o_col_feed_en,
   output logic [ROWS*COLS-1:0] o_latch
);
   localparam int unsigned DG = diags(ROWS, COLS);
   localparam int unsigned NF = (ROWS > COLS) ? ROWS : COLS;

   logic [DG-1:0] r_diag;
   logic [NF-1:0] r_feed;
   logic [PW-1:0] w_k;
   logic          w_nz;
   logic          w_seed;
   logic          w_feed;

   // Both are decoded one phase early so the registered pulse lands on the target cycle.
   always_comb begin
      w_k    = PW'(i_k_len);
      w_nz   = (i_k_len != '0);
      w_seed = i_active && w_nz && (i_phase == PW'(F0 - 1) + w_k);
      w_feed = i_active && w_nz && (i_phase >= PW'(F0 - 1)) && (i_phase <= PW'(F0 - 2) + w_k);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_diag <= '0;
         r_feed <= '0;
      end else begin
         r_diag[0] <= w_seed;
         for (int unsigned d = 1; d < DG; d++) r_diag[d] <= r_diag[d-1];
         r_feed[0] <= w_feed;
         for (int unsigned n = 1; n < NF; n++) r_feed[n] <= r_feed[n-1];
      end
   end

   always_comb begin
      o_latch       = '0;
      o_row_feed_en = '0;
      o_col_feed_en = '0;
      for (int unsigned i = 0; i < ROWS; i++) begin
         o_row_feed_en[i] = r_feed[i];
         for (int unsigned j = 0; j < COLS; j++) o_latch[latch_idx(i, j, COLS)] = r_diag[i + j];
      end
      for (int unsigned j = 0; j < COLS; j++) o_col_feed_en[j] = r_feed[j];
   end
endmodule

// File: rtl/systolic_cycle_scheduler.sv
// Sequences one output-stationary ROWS x COLS MAC tile: clear, K operand reads, feeds, latches.
// Optional SCHED_PERF_CNT_EN adds wrapping busy-cycle and tile counters.
module systolic_cycle_scheduler
   import systolic_sched_pkg::*;
#(
   parameter int unsigned ROWS   = 4,
   parameter int unsigned COLS   = 4,
   parameter int unsigned K_MAX  = 256,
   parameter int unsigned AW     = 8,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned KW     = $clog2(K_MAX + 1)
) (
   input  logic clk,
   input  logic rst,
   systolic_cycle_scheduler_if.master sif
`ifdef SCHED_PERF_CNT_EN
   ,
   output logic [31:0] perf_busy_cyc,
   output logic [15:0] perf_tiles
`endif
);
   localparam int unsigned F0   = f0_off(RD_LAT);
   localparam int unsigned PW   = phase_w(RD_LAT, K_MAX, ROWS, COLS);
   localparam int unsigned LAST = F0 + ROWS + COLS - 2;

   sched_state_t  r_state;
   sched_state_t  w_next;
   logic [PW-1:0] r_phase;
   logic [KW-1:0] r_k_len;
   logic [AW-1:0] r_a_base;
   logic [AW-1:0] r_b_base;
   logic [AW-1:0] r_k;
   logic [PW-1:0] w_k_pw;
   logic          w_accept;
   logic          w_active;

   assign w_k_pw   = PW'(r_k_len);
   assign w_accept = (r_state == S_IDLE) && sif.start;
   assign w_active = (r_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (sif.start) w_next = S_CLR;
         S_CLR:   w_next = (r_k_len == '0) ? S_DONE : S_FEED;
         S_FEED:  if (r_phase == w_k_pw + PW'(1)) w_next = S_DRAIN;
         S_DRAIN: if (r_phase == w_k_pw + PW'(LAST)) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // r_phase equals the cycle number of the tile (1 in CLR).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase  <= '0;
         r_k_len  <= '0;
         r_a_base <= '0;
         r_b_base <= '0;
         r_k      <= '0;
      end else begin
         if (w_accept) begin
            r_k_len  <= (sif.k_len > KW'(K_MAX)) ? KW'(K_MAX) : sif.k_len;
            r_a_base <= sif.a_base;
            r_b_base <= sif.b_base;
            r_phase  <= PW'(1);
            r_k      <= '0;
         end else if (w_active) begin
            r_phase <= r_phase + PW'(1);
         end
         if (r_state == S_FEED) r_k <= r_k + AW'(1);
      end
   end

   always_comb begin
      sif.busy      = w_active;
      sif.done      = (r_state == S_DONE);
      sif.arr_clr   = (r_state == S_CLR);
      sif.a_rd_en   = (r_state == S_FEED);
      sif.b_rd_en   = (r_state == S_FEED);
      sif.a_rd_addr = (r_state == S_FEED) ? r_a_base + r_k : '0;
      sif.b_rd_addr = (r_state == S_FEED) ? r_b_base + r_k : '0;
   end

   sched_diag_shift #(
      .ROWS (ROWS),
      .COLS (COLS),
      .KW   (KW),
      .PW   (PW),
      .F0   (F0)
   ) u_diag (
      .clk           (clk),
      .rst           (rst),
      .i_active      (w_active),
      .i_phase       (r_phase),
      .i_k_len       (r_k_len),
      .o_row_feed_en (sif.row_feed_en),
      .o_col_feed_en (sif.col_feed_en),
      .o_latch       (sif.latch)
   );

`ifdef SCHED_PERF_CNT_EN
   logic [31:0] r_perf_busy;
   logic [15:0] r_perf_tiles;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_busy  <= '0;
         r_perf_tiles <= '0;
      end else begin
         if (w_active)            r_perf_busy  <= r_perf_busy + 32'd1;
         if (r_state == S_DONE)   r_perf_tiles <= r_perf_tiles + 16'd1;
      end
   end

   assign perf_busy_cyc = r_perf_busy;
   assign perf_tiles    = r_perf_tiles;
`endif
endmodule

// File: tb/tb_systolic_cycle_scheduler.sv
// Self-checking bench for systolic_cycle_scheduler (default 4x4, RD_LAT=1, K_MAX=256).
// Expected outputs come from closed-form cycle windows plus a small PE-array data model.
module tb_systolic_cycle_scheduler;
   localparam int ROWS = 4, COLS = 4, K_MAX = 256, AW = 8, RD_LAT = 1;
   localparam int F0 = 2 + RD_LAT;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   systolic_cycle_scheduler_if #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .AW(AW)) sif ();
`ifdef SCHED_PERF_CNT_EN
   logic [31:0] perf_busy_cyc;
   logic [15:0] perf_tiles;
`endif

   systolic_cycle_scheduler #(
      .ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .AW(AW), .RD_LAT(RD_LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .sif (sif)
`ifdef SCHED_PERF_CNT_EN
      ,
      .perf_busy_cyc (perf_busy_cyc),
      .perf_tiles    (perf_tiles)
`endif
   );

   typedef struct packed {
      logic       busy, done, clr, ard;
      logic [7:0] aad;
      logic       brd;
      logic [7:0] bad;
      logic [3:0] row, col;
      logic [15:0] lat;
   } obs_t;

   typedef struct {
      int k; logic [7:0] ab, bb;
      int done_c, reads, lats; logic [7:0] la, lb;
   } vec_t;

   int checks = 0, failures = 0;
   int exp_busy = 0, exp_tiles = 0;

   task automatic check_obs(input string nm, input int t, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0d got=%h exp=%h", nm, t, act, exp);
      end
   endtask

   task automatic check_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
      end
   endtask

   function automatic obs_t get_obs();
      obs_t o;
      o.busy = sif.busy;  o.done = sif.done;  o.clr = sif.arr_clr;
      o.ard  = sif.a_rd_en; o.aad = sif.a_rd_en ? sif.a_rd_addr : 8'h00;
      o.brd  = sif.b_rd_en; o.bad = sif.b_rd_en ? sif.b_rd_addr : 8'h00;
      o.row  = sif.row_feed_en; o.col = sif.col_feed_en; o.lat = sif.latch;
      return o;
   endfunction

   // Expected outputs in cycle t of a tile accepted in cycle 0.
   function automatic obs_t model(input int t, input int k, input logic [7:0] ab, input logic [7:0] bb);
      obs_t e;
      int ke, tdone;
      e = '0;
      ke = (k > K_MAX) ? K_MAX : k;
      tdone = (ke == 0) ? 2 : F0 + ke + ROWS + COLS - 1;
      e.busy = (t >= 1) && (t <= tdone);
      e.done = (t == tdone);
      e.clr  = (t == 1);
      if (ke > 0 && t >= 2 && t <= ke + 1) begin
         e.ard = 1'b1; e.aad = ab + 8'(t - 2);
         e.brd = 1'b1; e.bad = bb + 8'(t - 2);
      end
      for (int i = 0; i < ROWS; i++) e.row[i] = (ke > 0) && (t >= F0 + i) && (t <= F0 + i + ke - 1);
      for (int j = 0; j < COLS; j++) e.col[j] = (ke > 0) && (t >= F0 + j) && (t <= F0 + j + ke - 1);
      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < COLS; j++) e.lat[i*COLS+j] = (ke > 0) && (t == F0 + ke + i + j);
      return e;
   endfunction

   // Cycle 0 is an IDLE cycle in which start is raised; returns after the DONE cycle.
   task automatic run_tile(input int k, input logic [7:0] ab, input logic [7:0] bb, input bit noise,
                           output int d_cyc, output int reads, output int lats,
                           output logic [7:0] la, output logic [7:0] lb);
      obs_t o;
      int ke, tdone;
      ke = (k > K_MAX) ? K_MAX : k;
      tdone = (ke == 0) ? 2 : F0 + ke + ROWS + COLS - 1;
      @(negedge clk);
      check_obs("idle", 0, get_obs(), model(0, k, ab, bb));
      sif.start = 1'b1; sif.k_len = 9'(k); sif.a_base = ab; sif.b_base = bb;
      d_cyc = -1; reads = 0; lats = 0; la = 8'h00; lb = 8'h00;
      for (int t = 1; t <= tdone; t++) begin
         @(negedge clk);
         o = get_obs();
         check_obs("cycle", t, o, model(t, k, ab, bb));
         if (o.done && d_cyc < 0) d_cyc = t;
         if (o.ard) begin reads++; la = o.aad; end
         if (o.brd) lb = o.bad;
         lats += $countones(o.lat);
         sif.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         if (noise) begin
            sif.k_len = 9'($urandom); sif.a_base = 8'($urandom); sif.b_base = 8'($urandom);
         end
      end
      exp_busy += tdone;
      exp_tiles++;
   endtask

   task automatic idle_step();
      @(negedge clk);
      check_obs("idle", 0, get_obs(), obs_t'(0));
      sif.start = 1'b0;
   endtask

   // PE array model: buffers, skew chains, edge muxes and accumulators driven by the DUT controls.
   bit   model_en = 1'b0;
   int   mc = 100;
   int   amem [256][ROWS];
   int   bmem [256][COLS];
   bit   av [64], bv [64];
   logic [7:0] ah [64], bh [64];
   int   rowv [ROWS][64];
   int   colv [COLS][64];
   int   acc [ROWS][COLS];
   int   outc [ROWS][COLS];

   always @(negedge clk) begin
      int s;
      if (model_en) begin
         av[mc%64] = sif.a_rd_en; ah[mc%64] = sif.a_rd_addr;
         bv[mc%64] = sif.b_rd_en; bh[mc%64] = sif.b_rd_addr;
         for (int i = 0; i < ROWS; i++) begin
            s = (mc - RD_LAT - i) % 64;
            rowv[i][mc%64] = (sif.row_feed_en[i] && av[s]) ? amem[ah[s]][i] : 0;
         end
         for (int j = 0; j < COLS; j++) begin
            s = (mc - RD_LAT - j) % 64;
            colv[j][mc%64] = (sif.col_feed_en[j] && bv[s]) ? bmem[bh[s]][j] : 0;
         end
         for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
               if (sif.arr_clr) acc[i][j] = 0;
               else acc[i][j] += rowv[i][(mc-j)%64] * colv[j][(mc-i)%64];
               if (sif.latch[i*COLS+j]) outc[i][j] = acc[i][j];
            end
         mc++;
      end
   end

   vec_t tbl [6];
   int   d_cyc, reads, lats;
   logic [7:0] la, lb;
   obs_t o;
   int   k;

   initial begin
      tbl[0] = '{k:8,   ab:8'h10, bb:8'h20, done_c:18,  reads:8,   lats:16, la:8'h17, lb:8'h27};
      tbl[1] = '{k:4,   ab:8'hFE, bb:8'h7C, done_c:14,  reads:4,   lats:16, la:8'h01, lb:8'h7F};
      tbl[2] = '{k:0,   ab:8'h33, bb:8'h44, done_c:2,   reads:0,   lats:0,  la:8'h00, lb:8'h00};
      tbl[3] = '{k:1,   ab:8'hFF, bb:8'h00, done_c:11,  reads:1,   lats:16, la:8'hFF, lb:8'h00};
      tbl[4] = '{k:261, ab:8'h00, bb:8'h80, done_c:266, reads:256, lats:16, la:8'hFF, lb:8'h7F};
      tbl[5] = '{k:256, ab:8'h05, bb:8'h06, done_c:266, reads:256, lats:16, la:8'h04, lb:8'h05};

      rst = 1'b1; sif.start = 1'b0; sif.k_len = '0; sif.a_base = '0; sif.b_base = '0;
      repeat (3) @(negedge clk);
      check_obs("reset", 0, get_obs(), obs_t'(0));
`ifdef SCHED_PERF_CNT_EN
      check_int("perf_reset_tiles", int'(perf_tiles), 0);
`endif
      rst = 1'b0;

      // Mid-tile reset: start during FEED is ignored, reset aborts without done.
      @(negedge clk);
      check_obs("idle", 0, get_obs(), obs_t'(0));
      sif.start = 1'b1; sif.k_len = 9'd8; sif.a_base = 8'h10; sif.b_base = 8'h20;
      for (int t = 1; t <= 6; t++) begin
         @(negedge clk);
         check_obs("abort_pre", t, get_obs(), model(t, 8, 8'h10, 8'h20));
         sif.start = (t == 3);
         if (t == 6) rst = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      check_obs("abort_c7", 7, get_obs(), obs_t'(0));
      exp_busy = 0; exp_tiles = 0;
      run_tile(2, 8'hA0, 8'hB0, 1'b0, d_cyc, reads, lats, la, lb);
      check_int("restart_done", d_cyc, F0 + 2 + ROWS + COLS - 1);

      // Directed table, tiles back to back with start noise while busy.
      for (int n = 0; n < 6; n++) begin
         run_tile(tbl[n].k, tbl[n].ab, tbl[n].bb, 1'b1, d_cyc, reads, lats, la, lb);
         check_int("tbl_done", d_cyc, tbl[n].done_c);
         check_int("tbl_reads", reads, tbl[n].reads);
         check_int("tbl_lats", lats, tbl[n].lats);
         check_int("tbl_last_a", int'(la), int'(tbl[n].la));
         check_int("tbl_last_b", int'(lb), int'(tbl[n].lb));
      end
      idle_step();
`ifdef SCHED_PERF_CNT_EN
      check_int("perf_tiles", int'(perf_tiles), exp_tiles);
      check_int("perf_busy", int'(perf_busy_cyc), exp_busy);
`endif

      // Identity A times ramp B through the array model; garbage elsewhere in the buffers.
      for (int a = 0; a < 256; a++) begin
         for (int i = 0; i < ROWS; i++) amem[a][i] = (a * 3 + i) % 7 + 1;
         for (int j = 0; j < COLS; j++) bmem[a][j] = (a * 5 + j) % 9 + 2;
      end
      for (int kk = 0; kk < 4; kk++) begin
         for (int i = 0; i < ROWS; i++) amem[8'h40 + kk][i] = (i == kk) ? 1 : 0;
         for (int j = 0; j < COLS; j++) bmem[8'h80 + kk][j] = kk * COLS + j + 1;
      end
      model_en = 1'b1;
      run_tile(4, 8'h40, 8'h80, 1'b0, d_cyc, reads, lats, la, lb);
      model_en = 1'b0;
      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < COLS; j++) check_int("pe_out_c", outc[i][j], i * COLS + j + 1);

      // Randomized tiles against the cycle-window model.
      for (int n = 0; n < 30; n++) begin
         k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(250, 300)) : int'($urandom_range(0, 12));
         run_tile(k, 8'($urandom), 8'($urandom), 1'b1, d_cyc, reads, lats, la, lb);
         check_int("rand_done", d_cyc, (k == 0) ? 2 : F0 + ((k > K_MAX) ? K_MAX : k) + ROWS + COLS - 1);
      end
      idle_step();
      idle_step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
